// File: rtl/alu_muldiv_seq_if.sv
// Request/response bundle between the execute-stage decode and the
// sequential multiply/divide unit.
interface alu_muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [6:0]      opcode_reg;
  logic [2:0]      AluControl_reg;
  logic [6:0]      funct7_reg;
  logic [XLEN-1:0] src_a;
  logic [XLEN-1:0] src_b;
  logic            flush;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] result;
  logic            illegal;

  modport master (
    output in_valid, opcode_reg, AluControl_reg, funct7_reg, src_a, src_b,
           flush, out_ready,
    input  in_ready, out_valid, result, illegal
  );

  modport slave (
    input  in_valid, opcode_reg, AluControl_reg, funct7_reg, src_a, src_b,
           flush, out_ready,
    output in_ready, out_valid, result, illegal
  );
endinterface

// File: rtl/alu_muldiv_seq.sv
// Sequential RV32M/RV64M multiply/divide unit. Shift-add multiply and
// restoring divide on operand magnitudes, UNROLL steps per clock, sign
// fix-up on the final step. Divide-by-zero, signed overflow and illegal
// encodings complete straight from IDLE.
//
// state  | meaning
// IDLE   | in_ready high, waiting for a request
// CALC   | iterating; counter holds remaining cycles
// DONE   | result/illegal held, out_valid high until consumed
module alu_muldiv_seq #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic             clk,
  input logic             rst,
  alu_muldiv_seq_if.slave bus
);
  localparam int N  = XLEN / UNROLL;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] hi_q, hi_d;      // product high / partial remainder
  logic [XLEN-1:0] lo_q, lo_d;      // multiplier / dividend-quotient
  logic [XLEN-1:0] opnd_q, opnd_d;  // multiplicand / divisor magnitude
  logic [2:0]      op_q, op_d;
  logic            neg_q, neg_d;
  logic [XLEN-1:0] result_q, result_d;
  logic            illegal_q, illegal_d;

  logic            rdy, accept, legal, a_neg, b_neg, neg_in, div0, ovf;
  logic [2:0]      f3;
  logic [XLEN-1:0] a_mag, b_mag, fin_res;
  logic [XLEN-1:0] hi_s, lo_s;
  logic [XLEN:0]   sum, r_sh, diff;
  logic [2*XLEN-1:0] prod, prod_f;
  logic [XLEN-1:0] quo_f, rem_f;

  // Request decode, operand signedness and magnitudes.
  always_comb begin
    f3     = bus.AluControl_reg;
    rdy    = (state_q == S_IDLE) && !rst;
    accept = bus.in_valid && rdy && !bus.flush;
    legal  = (bus.opcode_reg == 7'b0110011) && (bus.funct7_reg == 7'b0000001);
    a_neg  = (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b100 || f3 == 3'b110)
             && bus.src_a[XLEN-1];
    b_neg  = (f3 == 3'b001 || f3 == 3'b100 || f3 == 3'b110) && bus.src_b[XLEN-1];
    a_mag  = a_neg ? -bus.src_a : bus.src_a;
    b_mag  = b_neg ? -bus.src_b : bus.src_b;
    case (f3)
      3'b001, 3'b100: neg_in = a_neg ^ b_neg;
      3'b010, 3'b110: neg_in = a_neg;   // MULHSU, and REM follows the dividend
      default:        neg_in = 1'b0;
    endcase
    div0 = f3[2] && (bus.src_b == '0);
    ovf  = f3[2] && !f3[0] && (bus.src_a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.src_b);
  end

  // UNROLL iteration steps plus the sign-corrected final result.
  always_comb begin
    hi_s = hi_q;
    lo_s = lo_q;
    sum  = '0;
    r_sh = '0;
    diff = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (op_q[2]) begin
        r_sh = {hi_s, lo_s[XLEN-1]};
        diff = r_sh - {1'b0, opnd_q};
        if (!diff[XLEN]) begin
          hi_s = diff[XLEN-1:0];
          lo_s = {lo_s[XLEN-2:0], 1'b1};
        end else begin
          hi_s = r_sh[XLEN-1:0];
          lo_s = {lo_s[XLEN-2:0], 1'b0};
        end
      end else begin
        sum  = {1'b0, hi_s} + (lo_s[0] ? {1'b0, opnd_q} : '0);
        lo_s = {sum[0], lo_s[XLEN-1:1]};
        hi_s = sum[XLEN:1];
      end
    end
    prod   = {hi_s, lo_s};
    prod_f = neg_q ? -prod : prod;
    quo_f  = neg_q ? -lo_s : lo_s;
    rem_f  = neg_q ? -hi_s : hi_s;
    if (op_q[2])
      fin_res = op_q[1] ? rem_f : quo_f;
    else
      fin_res = (op_q[1:0] == 2'b00) ? prod_f[XLEN-1:0] : prod_f[2*XLEN-1:XLEN];
  end

  // Next-state and datapath loads; flush overrides everything.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    opnd_d    = opnd_q;
    op_d      = op_q;
    neg_d     = neg_q;
    result_d  = result_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          cnt_d  = CW'(N);
          op_d   = f3;
          neg_d  = neg_in;
          hi_d   = '0;
          lo_d   = f3[2] ? a_mag : b_mag;
          opnd_d = f3[2] ? b_mag : a_mag;
          if (!legal) begin
            result_d  = '0;
            illegal_d = 1'b1;
            state_d   = S_DONE;
          end else if (div0) begin
            result_d  = f3[1] ? bus.src_a : '1;
            illegal_d = 1'b0;
            state_d   = S_DONE;
          end else if (ovf) begin
            result_d  = f3[1] ? '0 : {1'b1, {(XLEN-1){1'b0}}};
            illegal_d = 1'b0;
            state_d   = S_DONE;
          end else begin
            state_d = S_CALC;
          end
        end
      end
      S_CALC: begin
        cnt_d = cnt_q - CW'(1);
        hi_d  = hi_s;
        lo_d  = lo_s;
        if (cnt_q == CW'(1)) begin
          result_d  = fin_res;
          illegal_d = 1'b0;
          state_d   = S_DONE;
        end
      end
      S_DONE: begin
        if (bus.out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (bus.flush) state_d = S_IDLE;
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      opnd_q    <= '0;
      op_q      <= '0;
      neg_q     <= 1'b0;
      result_q  <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      opnd_q    <= opnd_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      result_q  <= result_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.in_ready  = rdy;
  assign bus.out_valid = (state_q == S_DONE);
  assign bus.result    = result_q;
  assign bus.illegal   = illegal_q;
endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq: default instance (UNROLL=1) plus an
// UNROLL=4 instance for the shortened divide latency.
module tb_alu_muldiv_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  alu_muldiv_seq_if #(.XLEN(32)) bus ();
  alu_muldiv_seq_if #(.XLEN(32)) bus4 ();

  alu_muldiv_seq #(.XLEN(32), .UNROLL(1)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  alu_muldiv_seq #(.XLEN(32), .UNROLL(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

  localparam logic [6:0] OP_R = 7'b0110011;
  localparam logic [6:0] F7_M = 7'b0000001;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One request on the UNROLL=1 instance; hold>0 applies out_ready=0 for
  // that many cycles after out_valid rises.
  task automatic req(input string tag, input logic [2:0] f3, input logic [6:0] f7,
                     input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] exp_r, input logic exp_ill,
                     input int exp_lat, input int hold);
    int w, lat, rdy_hi;
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    chk({tag, "_rdy"}, bus.in_ready, 1);
    bus.out_ready      = (hold == 0);
    bus.in_valid       = 1'b1;
    bus.opcode_reg     = OP_R;
    bus.AluControl_reg = f3;
    bus.funct7_reg     = f7;
    bus.src_a          = a;
    bus.src_b          = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.src_a    = ~a;
    bus.src_b    = ~b;
    lat    = 0;
    rdy_hi = 0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (bus.in_ready) rdy_hi++;
      if (bus.out_valid) break;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_busy"}, rdy_hi, 0);
    chk({tag, "_res"}, bus.result, exp_r);
    chk({tag, "_ill"}, bus.illegal, exp_ill);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk({tag, "_hold_ov"}, bus.out_valid, 1);
      chk({tag, "_hold_res"}, bus.result, exp_r);
      chk({tag, "_hold_ill"}, bus.illegal, exp_ill);
      chk({tag, "_hold_rdy"}, bus.in_ready, 0);
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_post_ov"}, bus.out_valid, 0);
    chk({tag, "_post_rdy"}, bus.in_ready, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, ov_seen;
    bus.in_valid = 1'b0; bus.opcode_reg = '0; bus.AluControl_reg = '0; bus.funct7_reg = '0;
    bus.src_a = '0; bus.src_b = '0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus4.in_valid = 1'b0; bus4.opcode_reg = '0; bus4.AluControl_reg = '0; bus4.funct7_reg = '0;
    bus4.src_a = '0; bus4.src_b = '0; bus4.flush = 1'b0; bus4.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    chk("rst_rdy", bus.in_ready, 0);
    chk("rst_ov", bus.out_valid, 0);
    chk("rst_res", bus.result, 0);
    chk("rst_ill", bus.illegal, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_rel_rdy", bus.in_ready, 1);

    req("mul",      3'b000, F7_M, 32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0, 33, 0);
    req("mulh_8",   3'b001, F7_M, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33, 0);
    req("mulhu_8",  3'b011, F7_M, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 1'b0, 33, 0);
    req("mulhsu_8", 3'b010, F7_M, 32'h8000_0000, 32'h8000_0000, 32'hC000_0000, 1'b0, 33, 0);
    req("mulh_f",   3'b001, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 33, 0);
    req("mulhu_f",  3'b011, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 33, 0);
    req("mulhsu_f", 3'b010, F7_M, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 33, 0);
    req("div_m7",   3'b100, F7_M, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 1'b0, 33, 0);
    req("rem_m7",   3'b110, F7_M, 32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 1'b0, 33, 0);
    req("divu",     3'b101, F7_M, 32'd100,      32'd7,         32'd14,        1'b0, 33, 0);
    req("remu",     3'b111, F7_M, 32'd100,      32'd7,         32'd2,         1'b0, 33, 0);
    req("div_z",    3'b100, F7_M, 32'd5,        32'd0,         32'hFFFF_FFFF, 1'b0, 1, 0);
    req("remu_z",   3'b111, F7_M, 32'd5,        32'd0,         32'd5,         1'b0, 1, 0);
    req("div_ovf",  3'b100, F7_M, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0, 1, 0);
    req("rem_ovf",  3'b110, F7_M, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0, 1, 0);
    req("bp",       3'b101, F7_M, 32'd100,      32'd7,         32'd14,        1'b0, 33, 5);
    req("after_bp", 3'b111, F7_M, 32'd100,      32'd7,         32'd2,         1'b0, 33, 0);
    req("illegal",  3'b000, 7'b0000000, 32'd3,  32'd4,         32'd0,         1'b1, 1, 0);

    // UNROLL=4 divide
    bus4.in_valid = 1'b1; bus4.opcode_reg = OP_R; bus4.AluControl_reg = 3'b101;
    bus4.funct7_reg = F7_M; bus4.src_a = 32'd100; bus4.src_b = 32'd7;
    @(posedge clk);
    #1 bus4.in_valid = 1'b0;
    lat = 0;
    while (lat < 100) begin
      @(negedge clk);
      lat++;
      if (bus4.out_valid) break;
    end
    chk("u4_lat", lat, 9);
    chk("u4_res", bus4.result, 14);

    // flush in cycle 10 of a DIVU
    bus.in_valid = 1'b1; bus.AluControl_reg = 3'b101; bus.funct7_reg = F7_M;
    bus.src_a = 32'd100; bus.src_b = 32'd7;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    ov_seen = 0;
    repeat (9) begin
      @(negedge clk);
      if (bus.out_valid) ov_seen++;
    end
    @(negedge clk);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("flush_idle_rdy", bus.in_ready, 1);
    repeat (40) begin
      if (bus.out_valid) ov_seen++;
      @(negedge clk);
    end
    chk("flush_no_ov", ov_seen, 0);

    // flush together with in_valid: DIV 5/0 would show out_valid in cycle 1
    bus.in_valid = 1'b1; bus.flush = 1'b1; bus.AluControl_reg = 3'b100;
    bus.src_a = 32'd5; bus.src_b = 32'd0;
    @(posedge clk);
    #1 begin bus.in_valid = 1'b0; bus.flush = 1'b0; end
    @(negedge clk);
    chk("flush_acc_ov", bus.out_valid, 0);
    chk("flush_acc_rdy", bus.in_ready, 1);

    // rst mid-CALC (result/illegal still hold the illegal op's values: 0/1)
    bus.in_valid = 1'b1; bus.AluControl_reg = 3'b000;
    bus.src_a = 32'd7; bus.src_b = 32'd9;
    @(posedge clk);
    #1 bus.in_valid = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("rstc_ov", bus.out_valid, 0);
    chk("rstc_res", bus.result, 0);
    chk("rstc_ill", bus.illegal, 0);
    chk("rstc_rdy", bus.in_ready, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rstc_rel_rdy", bus.in_ready, 1);
    req("after_rst", 3'b000, F7_M, 32'd7, 32'd9, 32'd63, 1'b0, 33, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/alu_muldiv_seq.md
# alu_muldiv_seq

Parametrised sequential multiply/divide unit that extends the execute-stage ALU decode with the RV32M/RV64M operations. It decodes opcode/funct3/funct7, latches operands on a valid/ready handshake, and iterates shift-add multiply or restoring divide over XLEN/UNROLL cycles. It returns the result on a second valid/ready handshake and sits beside the single-cycle ALU in the execute stage.

## Interface
- XLEN, 32: operand/result width; 32 or 64.
- UNROLL, 1: iteration steps per cycle; power of 2, must divide XLEN.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  unit can accept a request; high only in IDLE and not in rst.
- opcode_reg  in  7  instruction opcode.
- AluControl_reg  in  3  funct3.
- funct7_reg  in  7  funct7.
- src_a  in  XLEN  rs1 value (dividend / multiplicand).
- src_b  in  XLEN  rs2 value (divisor / multiplier).
- flush  in  1  abort any in-flight operation.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts result.
- result  out  XLEN  operation result.
- illegal  out  1  qualified by out_valid; request was not an M-extension op.

## Operation
- Legal request: opcode_reg=0110011 and funct7_reg=0000001. funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- Any other encoding is illegal. The request goes IDLE→DONE with result=0 and illegal=1.
- Operands and decoded op are latched at acceptance (in_valid && in_ready). Inputs are don't-care afterwards.
- Multiply:
  - Operands are converted to magnitudes per signedness: MULH signed×signed, MULHSU signed a × unsigned b, MUL/MULHU unsigned.
  - A 2·XLEN product is accumulated; it is negated at the final step if the operand signs differ.
  - MUL returns the low XLEN bits; MULH* return the high XLEN bits.
- Divide:
  - Restoring division on magnitudes.
  - Signed quotient is negated if the signs differ. Signed remainder takes the sign of the dividend.
- Special cases complete without iterating (IDLE→DONE):
  - Divisor 0: DIV/DIVU result = all ones; REM/REMU result = src_a.
  - Signed overflow (src_a=most-negative, src_b=−1): DIV result = most-negative; REM result = 0.
- State machine:
  - IDLE: in_ready=1. On accept, go to CALC, or to DONE for illegal/special cases. Load iteration counter with XLEN/UNROLL.
  - CALC: perform UNROLL steps per edge and decrement the counter. On the edge where the counter reaches 0, write result with sign fix-up and go to DONE.
  - DONE: out_valid=1; result and illegal are held stable. On out_valid && out_ready, go to IDLE.
- flush: from any state, go to IDLE on the next edge and force out_valid=0. Flush beats in_valid in the same cycle, so no accept occurs. A result in DONE is discarded.
- No overlap: a new request cannot be accepted until the previous result has been consumed and IDLE is re-entered.

## Timing
- Reset values: state IDLE, out_valid 0, result 0, illegal 0, counter 0. in_ready is 0 while rst=1 and 1 in the first cycle after.
- Let N = XLEN/UNROLL.
- Iterative latency: if the handshake occurs in cycle 0, CALC occupies cycles 1..N and out_valid is first high in cycle N+1. Default parameters give cycle 33.
- Special-case and illegal latency: out_valid is high in cycle 1.
- DONE with out_ready=1 on its first cycle: out_valid high exactly 1 cycle, IDLE in the next cycle, so the next accept is no earlier than cycle N+2.
- rst mid-operation: IDLE on the next edge, same as flush; no out_valid pulse.
- All outputs are registered or decoded from registered state only. There are no combinational paths from in_* to out_*.

## Test plan
- MUL 7×0xFFFFFFFD, XLEN=32, UNROLL=1 -> result 0xFFFFFFEB, illegal=0, out_valid first high in cycle 33, in_ready=0 in cycles 1–33.
- High-word variants with a=b=0x80000000:
  - MULH -> 0x40000000.
  - MULHU -> 0x40000000.
  - MULHSU -> 0xC0000000.
- Same high-word variants with a=b=0xFFFFFFFF:
  - MULH -> 0x00000000.
  - MULHU -> 0xFFFFFFFE.
  - MULHSU -> 0xFFFFFFFF.
- Divide:
  - DIV −7/2 -> 0xFFFFFFFD; REM −7/2 -> 0xFFFFFFFF.
  - DIVU 100/7 -> 14; REMU 100/7 -> 2.
  - UNROLL=4: DIVU 100/7 -> 14 with out_valid in cycle 9.
- Special cases:
  - DIV 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
  - Each has out_valid in cycle 1.
  - Illegal request with funct7=0000000 -> illegal=1, result 0, cycle 1.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid rises -> result, illegal and out_valid stay stable and in_ready=0. Release -> IDLE next cycle, next request accepted.
- Flush and reset:
  - Assert flush in cycle 10 of a DIVU -> IDLE in cycle 11, no out_valid pulse ever for that op.
  - Assert flush in the same cycle as in_valid -> not accepted.
  - Assert rst mid-CALC -> all outputs return to their reset values next cycle.
